// File: rtl/uart_rx_pkg.sv
// Shared definitions for the uart_rx receiver: FSM state encoding, frame
// width and the baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_e;

  localparam int DATA_BITS = 8;

  // Whole clock cycles per bit; the fractional part is dropped.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte delivery channel from the receiver to its consumer (valid/ready).
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input  rx_ready);
  modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input.
// RST_VAL is the level both flops take in reset (idle level of the input).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops to settle metastability before use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and valid/ready byte delivery.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      usb_rx,
  uart_rx_if.master rx_if,
  output logic      frame_err,
  output logic      overrun,
  output logic      busy
`ifdef UART_RX_PARITY_EN
  , output logic    parity_err
`endif
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  logic             rx_s;
  state_e           state_q,     state_d;
  logic [CNT_W-1:0] baud_cnt_q,  baud_cnt_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       rx_data_q,   rx_data_d;
  logic             rx_valid_q,  rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q,   overrun_d;
  logic             commit;
  logic             expiry;
`ifdef UART_RX_PARITY_EN
  logic             par_err_q,   par_err_d;
  logic             par_bad_q,   par_bad_d;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (usb_rx),
    .q     (rx_s)
  );

  assign expiry = (baud_cnt_q == '0);

  // Frame FSM: next state, baud counter, bit index and shift register.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    commit      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d   = 1'b0;
    par_bad_d   = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          baud_cnt_d = HALF_LOAD;
        end
      end
      START: begin
        if (!expiry) begin
          baud_cnt_d = baud_cnt_q - 1'b1;
        end else if (!rx_s) begin
          state_d    = DATA;
          baud_cnt_d = FULL_LOAD;
          bit_idx_d  = 3'd0;
`ifdef UART_RX_PARITY_EN
          par_bad_d  = 1'b0;
`endif
        end else begin
          // Start bit did not survive to mid-bit: treat as a glitch.
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!expiry) begin
          baud_cnt_d = baud_cnt_q - 1'b1;
        end else begin
          shift_d    = {rx_s, shift_q[7:1]};
          baud_cnt_d = FULL_LOAD;
          bit_idx_d  = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!expiry) begin
          baud_cnt_d = baud_cnt_q - 1'b1;
        end else begin
          par_bad_d  = ^{shift_q, rx_s};
          par_err_d  = ^{shift_q, rx_s};
          baud_cnt_d = FULL_LOAD;
          state_d    = STOP;
        end
      end
`endif
      STOP: begin
        if (!expiry) begin
          baud_cnt_d = baud_cnt_q - 1'b1;
        end else if (rx_s) begin
`ifdef UART_RX_PARITY_EN
          commit  = !par_bad_q;
`else
          commit  = 1'b1;
`endif
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must return high before a new start.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: commit a byte, consume on handshake, flag overrun.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (rx_valid_q && rx_if.rx_ready) rx_valid_d = 1'b0;
    if (commit) begin
      if (rx_valid_q && !rx_if.rx_ready) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
      par_bad_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
      par_bad_q   <= par_bad_d;
`endif
    end
  end

  assign rx_if.rx_data  = rx_data_q;
  assign rx_if.rx_valid = rx_valid_q;
  assign frame_err      = frame_err_q;
  assign overrun        = overrun_q;
  assign busy           = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err     = par_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames, checked against
// a frame-level model (which bytes should arrive, how many flags fire).
module tb_uart_rx;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Sync delay + half bit + start/data(/parity) bit times + commit register.
  localparam int LAT = 2 + CPB / 2 + (9 + PAR_BITS) * CPB + 1;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic usb_rx = 1'b1;
  logic frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif

  uart_rx_if u_if ();

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .usb_rx    (usb_rx),
    .rx_if     (u_if),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    , .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, stab_viol = 0;
  logic [7:0] got_q[$];
  logic [7:0] prev_data;
  logic       prev_vld = 1'b0;
  logic       prev_hs  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Record accepted bytes, flag pulses and data stability while valid.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
      prev_hs  = 1'b0;
    end else begin
      if (u_if.rx_valid && u_if.rx_ready) got_q.push_back(u_if.rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
      if (prev_vld && !prev_hs && u_if.rx_valid && (u_if.rx_data != prev_data)) stab_viol++;
      prev_vld  = u_if.rx_valid;
      prev_hs   = u_if.rx_valid && u_if.rx_ready;
      prev_data = u_if.rx_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: a frame yields a byte only with a high stop bit and good parity.
  function automatic logic delivers(input logic stop_b, input logic par_flip);
    return stop_b && !par_flip;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip);
    usb_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      usb_rx = b[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    usb_rx = (^b) ^ par_flip;
    tick(CPB);
`endif
    usb_rx = stop_b;
    tick(CPB);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, fe0, ov0, pe0, lat;
    logic vld_next;
    logic [7:0] dat_at;
    logic [7:0] exp_q[$];
    int exp_fe, exp_pe;

    u_if.rx_ready = 1'b1;
    tick(3);
    chk("rst_valid", 32'(u_if.rx_valid), 0);
    chk("rst_data",  32'(u_if.rx_data), 0);
    chk("rst_fe",    32'(frame_err), 0);
    chk("rst_ov",    32'(overrun), 0);
    chk("rst_busy",  32'(busy), 0);
    rst_n = 1'b1;
    tick(5);

    // Single byte, consumer always ready: latency and one-cycle valid.
    base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    lat = 0; vld_next = 1'b1; dat_at = 8'h00;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        while (lat < 300) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          if (u_if.rx_valid) break;
        end
        dat_at = u_if.rx_data;
        @(negedge clk);
        vld_next = u_if.rx_valid;
      end
    join
    tick(2);
    chk("a5_latency", 32'(lat), 32'(LAT));
    chk("a5_data_at_valid", 32'(dat_at), 32'hA5);
    chk("a5_valid_1cyc", 32'(vld_next), 0);
    chk("a5_count", 32'(got_q.size() - base), 1);
    if (got_q.size() > base) chk("a5_byte", 32'(got_q[base]), 32'hA5);
    chk("a5_fe", 32'(fe_cnt - fe0), 0);
    chk("a5_ov", 32'(ov_cnt - ov0), 0);

    // Two bytes with the consumer stalled: the second is dropped.
    base = got_q.size(); ov0 = ov_cnt;
    u_if.rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    tick(3);
    chk("ovr_valid", 32'(u_if.rx_valid), 1);
    chk("ovr_data",  32'(u_if.rx_data), 32'h3C);
    chk("ovr_pulses", 32'(ov_cnt - ov0), 1);
    chk("ovr_no_accept", 32'(got_q.size() - base), 0);
    u_if.rx_ready = 1'b1;
    tick(1);
    @(negedge clk);
    chk("ovr_valid_clear", 32'(u_if.rx_valid), 0);
    chk("ovr_accept_cnt", 32'(got_q.size() - base), 1);
    if (got_q.size() > base) chk("ovr_accept_byte", 32'(got_q[base]), 32'h3C);
    tick(1);

    // Low stop bit, then a held break.
    base = got_q.size(); fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    tick(50);
    chk("fe_busy_low", 32'(busy), 1);
    chk("fe_pulses", 32'(fe_cnt - fe0), 1);
    chk("fe_valid", 32'(u_if.rx_valid), 0);
    usb_rx = 1'b1;
    tick(1);
    chk("fe_busy_after_rise", 32'(busy), 1);
    tick(3);
    chk("fe_busy_idle", 32'(busy), 0);
    chk("fe_no_byte", 32'(got_q.size() - base), 0);
    chk("fe_pulses_final", 32'(fe_cnt - fe0), 1);

    // Short glitch on an idle line.
    base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    usb_rx = 1'b0;
    tick(3);
    usb_rx = 1'b1;
    tick(2);
    chk("gl_busy", 32'(busy), 1);
    tick(20);
    chk("gl_idle", 32'(busy), 0);
    chk("gl_no_byte", 32'(got_q.size() - base), 0);
    chk("gl_fe", 32'(fe_cnt - fe0), 0);
    chk("gl_ov", 32'(ov_cnt - ov0), 0);

    // Reset during bit 4 of 0xFF, then a clean 0x81.
    base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        tick(CPB * 5 + 3);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_valid", 32'(u_if.rx_valid), 0);
        chk("mr_data",  32'(u_if.rx_data), 0);
        chk("mr_fe",    32'(frame_err), 0);
        chk("mr_ov",    32'(overrun), 0);
        chk("mr_busy",  32'(busy), 0);
      end
    join
    tick(1);
    rst_n = 1'b1;
    tick(3);
    send_frame(8'h81, 1'b1, 1'b0);
    tick(3);
    chk("mr_count", 32'(got_q.size() - base), 1);
    if (got_q.size() > base) chk("mr_byte", 32'(got_q[base]), 32'h81);
    chk("mr_fe_after", 32'(fe_cnt - fe0), 0);
    chk("mr_ov_after", 32'(ov_cnt - ov0), 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so the correct even-parity bit is 1.
    base = got_q.size(); pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    tick(3);
    chk("par_ok_count", 32'(got_q.size() - base), 1);
    if (got_q.size() > base) chk("par_ok_byte", 32'(got_q[base]), 32'h07);
    chk("par_ok_pe", 32'(pe_cnt - pe0), 0);
    base = got_q.size();
    send_frame(8'h07, 1'b1, 1'b1);
    tick(3);
    chk("par_bad_pe", 32'(pe_cnt - pe0), 1);
    chk("par_bad_no_byte", 32'(got_q.size() - base), 0);
    chk("par_bad_fe", 32'(fe_cnt - fe0), 0);
`endif

    // Random frames: random data, occasional bad stop (and parity).
    base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    exp_fe = 0; exp_pe = 0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      logic stop_b, flip;
      b      = 8'($urandom_range(0, 255));
      stop_b = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
      flip   = ($urandom_range(0, 4) == 0);
`else
      flip   = 1'b0;
`endif
      if (delivers(stop_b, flip)) exp_q.push_back(b);
      if (!stop_b) exp_fe++;
      if (flip) exp_pe++;
      send_frame(b, stop_b, flip);
      usb_rx = 1'b1;
      tick($urandom_range(4, 12));
    end
    tick(5);
    chk("rnd_count", 32'(got_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) chk($sformatf("rnd_byte%0d", i), 32'(got_q[base + i]), 32'(exp_q[i]));
    end
    chk("rnd_fe", 32'(fe_cnt - fe0), 32'(exp_fe));
    chk("rnd_ov", 32'(ov_cnt - ov0), 0);
    chk("rnd_pe", 32'(pe_cnt - pe0), 32'(exp_pe));
    chk("data_stable", 32'(stab_viol), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 asynchronous serial receiver on the board's usb_rx pin (host-to-FPGA direction from the USB bridge); the opposite end of the bridge's transmit path.
- Synchronises the line and oversamples at the mid-point of each bit.
- Delivers each received byte on a valid/ready interface to downstream logic, e.g. the LED pattern register.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- Derived localparam CLKS_PER_BIT = CLK_HZ/BAUD, truncated; 868 at the defaults. Must be >= 4; elaborate-time error otherwise.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- usb_rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  received byte, LSB first on the wire.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while the previous byte was unconsumed.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: 2-FF synchroniser = 1, state = IDLE, rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, busy = 0, counters = 0.
- Synchroniser: usb_rx passes through two flops; all decisions use the second flop (rx_s). The 2-cycle delay is included in the latencies below.
- One down-counter, baud_cnt; "expiry" means baud_cnt == 0. Bit index is 3 bits.
- IDLE:
  - On rx_s == 0: go to START and load baud_cnt = CLKS_PER_BIT/2 - 1.
- START:
  - On expiry, sample rx_s.
  - Sample 0: go to DATA, baud_cnt = CLKS_PER_BIT-1, bit_idx = 0.
  - Sample 1: glitch. Return to IDLE; no output and no flags.
- DATA:
  - On each expiry, shift rx_s into the MSB of the shift register (shift right), reload baud_cnt, increment bit_idx.
  - After the sample at bit_idx == 7: go to STOP (or PARITY, see below).
- STOP, on expiry, sample rx_s:
  - Sample 1: commit the byte (see handshake) and go to IDLE.
  - Sample 0: pulse frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s == 1, then go to IDLE. This prevents a break condition from retriggering START.
- Commit and handshake:
  - rx_valid && !rx_ready at commit: rx_data and rx_valid are unchanged, overrun pulses, the new byte is dropped.
  - rx_valid && rx_ready in the commit cycle: the old byte is consumed, the new byte is loaded, rx_valid stays 1, no overrun.
  - !rx_valid at commit: load rx_data, rx_valid <= 1.
  - rx_valid clears the cycle after rx_valid && rx_ready when no commit coincides.
  - rx_data is stable while rx_valid is high.
- Latency: rx_valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (+1 for the commit register) after the usb_rx falling edge.
- Reset mid-frame: immediate return to IDLE, partial byte lost, outputs at reset values.
- Line held low from reset release: enter START, validate, receive 0x00, then a framing error, then WAIT_HIGH.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled one bit time after bit 7.
  - Even parity: XOR of data bits and parity bit must be 0.
  - Adds output port parity_err (1 bit, reset 0), a one-cycle pulse on mismatch.
  - A byte with a parity error is discarded, but reception continues to STOP normally.
- Undefined: no PARITY state, no parity_err port, 8N1 only.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH}, 3-bit encoding.
  - Constant DATA_BITS = 8.
  - Function clks_per_bit(clk_hz, baud).
- Sub-module sync_2ff (1-bit, reset value parameter, default 1), reusable by other board inputs.
- The baud counter stays inline.

Test Plan (CLK_HZ=1000000, BAUD=100000, CLKS_PER_BIT=10):
- Send 0xA5 with rx_ready=1 -> rx_valid pulses for 1 cycle with rx_data=0xA5, 2+5+90+1 = 98 cycles after the start edge; no flags.
- Send 0x3C then 0xC3 back-to-back with rx_ready=0 -> rx_data stays 0x3C, rx_valid stays 1, overrun pulses once at the second stop. Then raise rx_ready -> rx_valid clears next cycle.
- Send 0x55 with the stop bit driven low -> frame_err pulses once, rx_valid stays 0. Hold the line low 50 cycles, then high -> busy stays 1 until 2 cycles after the rise, and no spurious byte.
- Drive a 3-cycle low glitch on an idle line -> returns to IDLE after the START sample; rx_valid, frame_err and overrun all stay 0.
- Assert rst_n=0 during bit 4 of 0xFF, release, then send 0x81 -> only 0x81 is delivered, correct, and all outputs are 0 while in reset.
- UART_RX_PARITY_EN defined: send 0x07 with parity bit 1 -> rx_data=0x07 delivered. Send 0x07 with parity bit 0 -> parity_err pulses, no rx_valid.
